// File: rtl/display_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan controller.
package display_pkg;

  typedef enum logic [0:0] {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } scan_state_t;

  localparam logic [7:0] ANODE_OFF = 8'hFF;
  // Wide enough for PRESCALE up to 2^20 and BLANK_CYCLES up to 255.
  localparam int unsigned CNT_W = 21;

  function automatic logic [7:0] anode_onehot_low(input logic [2:0] idx);
    return ~(8'h01 << idx);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_anode_decode.sv
// Combinational anode driver: one active-low enable for the current digit,
// all anodes off when the digit is masked or the slot is not in its lit phase.
module anode_decode
  import display_pkg::*;
(
  input  logic [2:0] digit_sel_i,
  input  logic       mask_bit_i,
  input  logic       show_i,
  output logic [7:0] anodos_o
);

  // Select the single low anode bit for an enabled, lit digit.
  always_comb begin
    anodos_o = ANODE_OFF;
    if (show_i && mask_bit_i) begin
      anodos_o = anode_onehot_low(digit_sel_i);
    end else begin
      anodos_o = ANODE_OFF;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Eight-digit display scanner with double-buffered, frame-synchronous loads.
// Define DISPLAY_SCAN_GHOST_BLANK_EN to insert an all-off BLANK gap between digit slots.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned PRESCALE     = 100000,
  parameter int unsigned BLANK_CYCLES = 16,
  parameter logic [7:0]  DIGIT_MASK   = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [2:0]  digit_sel,
  output logic [3:0]  nibble,
  output logic        dp,
  output logic [7:0]  anodos,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(PRESCALE - 1);
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`else
  logic unused_blank_s;
  assign unused_blank_s = (BLANK_CYCLES != 0);
`endif

  scan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       digit_q, digit_d;
  logic [31:0]      active_data_q, active_data_d;
  logic [7:0]       active_dp_q, active_dp_d;
  logic [31:0]      shadow_data_q, shadow_data_d;
  logic [7:0]       shadow_dp_q, shadow_dp_d;
  logic             pending_q, pending_d;
  logic             slot_end_s;
  logic             frame_end_s;
  logic             xfer_s;
  logic             show_s;

  // Slot timing: SHOW for PRESCALE cycles, optional BLANK gap, then next digit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    digit_d    = digit_q;
    slot_end_s = 1'b0;
    case (state_q)
      SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          cnt_d = {CNT_W{1'b0}};
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
          state_d = BLANK;
`else
          digit_d    = digit_q + 3'd1;
          slot_end_s = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      BLANK: begin
`ifdef DISPLAY_SCAN_GHOST_BLANK_EN
        if (cnt_q == BLANK_LAST) begin
          cnt_d      = {CNT_W{1'b0}};
          state_d    = SHOW;
          digit_d    = digit_q + 3'd1;
          slot_end_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`else
        state_d = SHOW;
        cnt_d   = {CNT_W{1'b0}};
`endif
      end
      default: begin
        state_d = SHOW;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  assign frame_end_s = slot_end_s && (digit_q == 3'd7);
  assign xfer_s      = load_valid && load_ready;

  // Shadow accepts one load; it moves to the active buffer only at a frame boundary.
  always_comb begin
    active_data_d = active_data_q;
    active_dp_d   = active_dp_q;
    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pending_d     = pending_q;
    if (xfer_s) begin
      shadow_data_d = data_in;
      shadow_dp_d   = dp_in;
      pending_d     = 1'b1;
    end else if (frame_end_s && pending_q) begin
      active_data_d = shadow_data_q;
      active_dp_d   = shadow_dp_q;
      pending_d     = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= SHOW;
      cnt_q         <= {CNT_W{1'b0}};
      digit_q       <= 3'd0;
      active_data_q <= 32'h0000_0000;
      active_dp_q   <= 8'h00;
      shadow_data_q <= 32'h0000_0000;
      shadow_dp_q   <= 8'h00;
      pending_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      digit_q       <= digit_d;
      active_data_q <= active_data_d;
      active_dp_q   <= active_dp_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pending_q     <= pending_d;
    end
  end

  // Outputs are forced to their idle values for the whole time reset is held.
  assign show_s     = (state_q == SHOW) && !reset;
  assign load_ready = !pending_q && !reset;
  assign frame_done = frame_end_s && !reset;
  assign digit_sel  = digit_q;
  assign nibble     = active_data_q[{digit_q, 2'b00} +: 4];
  assign dp         = active_dp_q[digit_q];

  anode_decode u_anode_decode (
    .digit_sel_i (digit_q),
    .mask_bit_i  (DIGIT_MASK[digit_q]),
    .show_i      (show_s),
    .anodos_o    (anodos)
  );

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 100000: clock cycles each digit slot is shown (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_CYCLES, default 16: all-anodes-off cycles between slots (legal range 1..255).
REQ-003 SHALL have parameter DIGIT_MASK, default 8'hFF: bit i = 1 enables digit i, 0 keeps it dark.
REQ-004 SHALL have port clk, input, 1: the only clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port data_in, input, 32: eight hex nibbles; nibble i drives digit i.
REQ-007 SHALL have port dp_in, input, 8: per-digit decimal points, captured with data_in.
REQ-008 SHALL have port load_valid, input, 1: the requester offers data_in/dp_in.
REQ-009 SHALL have port load_ready, output, 1: the shadow buffer is free.
REQ-010 SHALL have port digit_sel, output, 3: index of the current slot.
REQ-011 SHALL have port nibble, output, 4: active nibble for digit_sel.
REQ-012 SHALL have port dp, output, 1: active decimal point for digit_sel.
REQ-013 SHALL have port anodos, output, 8: active-low anode enables.
REQ-014 SHALL have port frame_done, output, 1: one-cycle pulse at the end of the digit-7 slot.

Function
REQ-015 SHALL be a state machine with states SHOW and BLANK, driven by a cycle counter.
REQ-016 SHOW SHALL last exactly PRESCALE cycles; anodos SHALL have bit digit_sel low only if DIGIT_MASK[digit_sel]=1; all other bits are 1.
REQ-017 BLANK SHALL last exactly BLANK_CYCLES cycles with anodos=8'hFF; then digit_sel increments and the state returns to SHOW.
REQ-018 digit_sel SHALL wrap 7->0; masked digits still consume their full slot, so brightness stays uniform.
REQ-019 frame_done SHALL pulse on the last cycle of the digit-7 slot (the last BLANK cycle; the last SHOW cycle when blanking is compiled out).
REQ-020 Handshake: a transfer SHALL occur when load_valid and load_ready are both 1; data_in and dp_in go to the shadow buffer and pending is set.
REQ-021 load_ready SHALL equal !pending.
REQ-022 On the frame_done cycle with pending=1, the shadow buffer SHALL copy to the active buffer and pending SHALL clear.
REQ-023 After that copy, the new data SHALL be visible from the first cycle of digit 0, and load_ready SHALL be 1 on the next cycle.
REQ-024 A transfer in the same cycle as frame_done with pending=0 SHALL only fill the shadow buffer; it is applied at the following frame boundary (no bypass).
REQ-025 nibble and dp SHALL always come from the active buffer, never the shadow buffer; no tearing within a frame.

Reset
REQ-026 While reset=1, the block SHALL drive: state=SHOW, counter=0, digit_sel=0, active=0, shadow=0, pending=0, anodos=8'hFF, frame_done=0, load_ready=0.
REQ-027 On the first cycle after reset, load_ready=1 and digit 0 is shown for a full PRESCALE slot.
REQ-028 Reset mid-slot or mid-BLANK SHALL discard all buffers and any pending load.

Configuration
REQ-029 Macro DISPLAY_SCAN_GHOST_BLANK_EN defined: BLANK state present, as specified above.
REQ-030 Macro undefined: no BLANK state; SHOW advances directly to the next digit; BLANK_CYCLES is ignored; the slot period equals PRESCALE.

Structure
REQ-031 Package display_pkg SHALL hold the scan_state_t enum (SHOW, BLANK) and the constant ANODE_OFF=8'hFF.
REQ-032 A sub-module anode_decode SHALL map (digit_sel, mask bit, show flag) to anodos combinationally; the counter, FSM and buffers stay in display_scan_ctrl.

Verification (PRESCALE=4, BLANK_CYCLES=2, DIGIT_MASK=8'hFF unless stated)
REQ-033 Release reset -> digit 0 anodos=8'hFE for 4 cycles, 8'hFF for 2, then 8'hFD; frame_done every 48 cycles.
REQ-034 DIGIT_MASK=8'h0F -> digits 4..7 give anodos=8'hFF for full slots; frame period unchanged at 48.
REQ-035 Load 32'h89ABCDEF mid-frame -> load_ready=0 until frame_done; next frame nibble sequence F,E,D,C,B,A,9,8.
REQ-036 Load 32'h1 exactly on the frame_done cycle -> shown one frame later; load_ready=0 during the intervening frame.
REQ-037 Assert reset during BLANK of digit 5 with a pending load -> outputs return to reset values; the pending data is never displayed.
REQ-038 Build without the macro -> anodos never 8'hFF with the full mask; frame period is 32 cycles.
